// File: rtl/sr_ff_bank.sv
// Bank of WIDTH independent clocked SR flip-flops with selectable S=R=1
// resolution, per-channel conflict flags, and sticky/counted conflict statistics.
module sr_ff_bank #(
  parameter int unsigned       WIDTH         = 8,
  parameter int unsigned       CONFLICT_MODE = 0,
  parameter logic [WIDTH-1:0]  RESET_VALUE   = '0,
  parameter int unsigned       CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             EN,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  input  logic             CLR_ERR,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_not,
  output logic [WIDTH-1:0] CONFLICT,
  output logic             ERR_STICKY,
  output logic [CNT_W-1:0] ERR_CNT
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Conflict resolution decoded once; modes above 3 fall back to hold.
  localparam bit MODE_SET    = (CONFLICT_MODE == 32'd1);
  localparam bit MODE_RESET  = (CONFLICT_MODE == 32'd2);
  localparam bit MODE_TOGGLE = (CONFLICT_MODE == 32'd3);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] conflict_q, conflict_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] both_c;
  logic             event_c;

  // Next-state: per-channel SR update, conflict flags and error statistics.
  always_comb begin
    q_d        = q_q;
    conflict_d = '0;
    sticky_d   = sticky_q;
    cnt_d      = cnt_q;
    both_c     = S & R;
    event_c    = EN & (|both_c);

    if (EN) begin
      conflict_d = both_c;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        case ({S[i], R[i]})
          2'b10: q_d[i] = 1'b1;
          2'b01: q_d[i] = 1'b0;
          2'b11: begin
            if (MODE_SET)         q_d[i] = 1'b1;
            else if (MODE_RESET)  q_d[i] = 1'b0;
            else if (MODE_TOGGLE) q_d[i] = ~q_q[i];
            else                  q_d[i] = q_q[i];
          end
          default: q_d[i] = q_q[i];
        endcase
      end
    end

    // Clear wins over a same-edge conflict event.
    if (CLR_ERR) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end else if (event_c) begin
      sticky_d = 1'b1;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q        <= RESET_VALUE;
      conflict_q <= '0;
      sticky_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      q_q        <= q_d;
      conflict_q <= conflict_d;
      sticky_q   <= sticky_d;
      cnt_q      <= cnt_d;
    end
  end

  assign Q          = q_q;
  assign Q_not      = ~q_q;
  assign CONFLICT   = conflict_q;
  assign ERR_STICKY = sticky_q;
  assign ERR_CNT    = cnt_q;

endmodule
